// File: rtl/beam_steering.sv
// beam_steering
//   Transmit-side beam steering. A mono sample stream is written into a
//   circular delay buffer and read back at two taps: left at a fixed delay
//   of WINDOW_SIZE samples, right at 2*WINDOW_SIZE - active_index samples.
//   The index uses the same 0..2*WINDOW_SIZE scale the receive beamformer
//   reports, so a detected index can be replayed unchanged.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   sample_in       mono input sample (passed through bit-exact)
//   sample_valid    sample_in accepted on this edge
//   steer_index     requested steering index (legal 0..2*WINDOW_SIZE)
//   steer_load      capture steer_index this cycle
//   left_data_out   delayed left sample
//   right_data_out  delayed right sample
//   out_valid       one-cycle strobe, left/right updated
//   active_index    steering index currently applied
//   steer_busy      a legal load is waiting for the next frame boundary
//   steer_error     sticky flag, an out-of-range index was loaded
module beam_steering #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_SIZE = 30,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  sample_in,
  input  logic                   sample_valid,
  input  logic [INDEX_WIDTH-1:0] steer_index,
  input  logic                   steer_load,
  output logic [DATA_WIDTH-1:0]  left_data_out,
  output logic [DATA_WIDTH-1:0]  right_data_out,
  output logic                   out_valid,
  output logic [INDEX_WIDTH-1:0] active_index,
  output logic                   steer_busy,
  output logic                   steer_error
);

  localparam int DEPTH   = 2 * WINDOW_SIZE + 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int SUM_W   = PTR_W + 1;
  localparam int FRAME_W = $clog2(WINDOW_SIZE + 1);

  localparam logic [PTR_W-1:0]       PTR_LAST     = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]       FILL_LAST    = PTR_W'(2 * WINDOW_SIZE);
  localparam logic [FRAME_W-1:0]     FRAME_LAST   = FRAME_W'(WINDOW_SIZE - 1);
  localparam logic [INDEX_WIDTH-1:0] MAX_INDEX    = INDEX_WIDTH'(2 * WINDOW_SIZE);
  localparam logic [INDEX_WIDTH-1:0] CENTER_INDEX = INDEX_WIDTH'(WINDOW_SIZE);

  typedef enum logic {FILL, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]       fill_cnt_reg, fill_cnt_next;
  logic [FRAME_W-1:0]     frame_cnt_reg, frame_cnt_next;
  logic [DATA_WIDTH-1:0]  left_reg, left_next;
  logic [DATA_WIDTH-1:0]  right_reg, right_next;
  logic                   valid_reg, valid_next;
  logic [INDEX_WIDTH-1:0] active_reg, active_next;
  logic [INDEX_WIDTH-1:0] pending_reg, pending_next;
  logic                   busy_reg, busy_next;
  logic                   error_reg, error_next;

  logic                   emit;
  logic                   boundary;

  // Delay buffer; contents are deliberately left uninitialised on reset,
  // the FILL warm-up guarantees nothing stale is ever emitted.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (sample_valid) begin
      mem[wr_ptr_reg] <= sample_in;
    end
  end

  // Tap 0 = left, tap 1 = right.
  logic [1:0][INDEX_WIDTH-1:0] delay;
  logic [1:0][DATA_WIDTH-1:0]  tap;

  assign delay[0] = CENTER_INDEX;
  assign delay[1] = MAX_INDEX - active_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tap
      logic [SUM_W-1:0] addr_sum;
      logic [PTR_W-1:0] rd_addr;
      // Depth is added before the delay is subtracted so the sum never
      // goes negative; one conditional subtract completes the modulo.
      assign addr_sum = SUM_W'(wr_ptr_reg) + SUM_W'(DEPTH) - SUM_W'(delay[gi]);
      assign rd_addr  = (addr_sum >= SUM_W'(DEPTH)) ? PTR_W'(addr_sum - SUM_W'(DEPTH))
                                                    : PTR_W'(addr_sum);
      // Zero delay means the sample being written now, so bypass the RAM.
      assign tap[gi]  = (delay[gi] == '0) ? sample_in : mem[rd_addr];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    fill_cnt_next  = fill_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    left_next      = left_reg;
    right_next     = right_reg;
    valid_next     = 1'b0;
    active_next    = active_reg;
    pending_next   = pending_reg;
    busy_next      = busy_reg;
    error_next     = error_reg;
    emit           = 1'b0;
    boundary       = 1'b0;

    if (sample_valid) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      if (state_reg == FILL) begin
        if (fill_cnt_reg == FILL_LAST) begin
          state_next = RUN;
          emit       = 1'b1;
        end else begin
          fill_cnt_next = fill_cnt_reg + 1'b1;
        end
      end else begin
        emit = 1'b1;
      end
    end

    // frame_cnt_reg is the frame position of the sample being emitted now;
    // it sits at 0 throughout FILL so the first RUN output is position 0.
    if (emit) begin
      left_next      = tap[0];
      right_next     = tap[1];
      valid_next     = 1'b1;
      boundary       = (state_reg == RUN) && (frame_cnt_reg == FRAME_LAST);
      frame_cnt_next = (frame_cnt_reg == FRAME_LAST) ? '0 : frame_cnt_reg + 1'b1;
    end

    // The boundary sample itself was produced with the old index above;
    // the pending index takes effect from the following sample.
    if (boundary && busy_reg) begin
      active_next = pending_reg;
      busy_next   = 1'b0;
    end

    // Evaluated after the boundary swap so a load on a boundary cycle
    // becomes the next pending value rather than being applied.
    if (steer_load) begin
      if (steer_index <= MAX_INDEX) begin
        if (state_reg == FILL) begin
          active_next = steer_index;
        end else begin
          pending_next = steer_index;
          busy_next    = 1'b1;
        end
      end else begin
        error_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= FILL;
      wr_ptr_reg    <= '0;
      fill_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      left_reg      <= '0;
      right_reg     <= '0;
      valid_reg     <= 1'b0;
      active_reg    <= CENTER_INDEX;
      pending_reg   <= CENTER_INDEX;
      busy_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      fill_cnt_reg  <= fill_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      left_reg      <= left_next;
      right_reg     <= right_next;
      valid_reg     <= valid_next;
      active_reg    <= active_next;
      pending_reg   <= pending_next;
      busy_reg      <= busy_next;
      error_reg     <= error_next;
    end
  end

  assign left_data_out  = left_reg;
  assign right_data_out = right_reg;
  assign out_valid      = valid_reg;
  assign active_index   = active_reg;
  assign steer_busy     = busy_reg;
  assign steer_error    = error_reg;

endmodule

// File: tb/tb_beam_steering.sv
// tb_beam_steering
//   Scoreboard bench for beam_steering. A behavioural model keeps the full
//   history of accepted samples and derives each expected left/right pair
//   directly from the delay definitions; expected pairs are queued when the
//   producing sample is driven and popped when the DUT strobes out_valid.
module tb_beam_steering;

  localparam int DW   = 16;
  localparam int WS   = 30;
  localparam int IW   = 6;
  localparam int MAXI = 2 * WS;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic [IW-1:0] steer_index;
  logic          steer_load;
  logic [DW-1:0] left_data_out;
  logic [DW-1:0] right_data_out;
  logic          out_valid;
  logic [IW-1:0] active_index;
  logic          steer_busy;
  logic          steer_error;

  beam_steering #(.DATA_WIDTH(DW), .WINDOW_SIZE(WS), .INDEX_WIDTH(IW)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .steer_index    (steer_index),
    .steer_load     (steer_load),
    .left_data_out  (left_data_out),
    .right_data_out (right_data_out),
    .out_valid      (out_valid),
    .active_index   (active_index),
    .steer_busy     (steer_busy),
    .steer_error    (steer_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard and model state
  int sb_l[$];
  int sb_r[$];
  int hist[$];
  int m_count, m_pos, m_active, m_pending;
  bit m_run, m_busy, m_error, m_exp_valid;
  int last_l, last_r;
  int out_no;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    sb_l.delete();
    sb_r.delete();
    m_count     = 0;
    m_pos       = 0;
    m_active    = WS;
    m_pending   = WS;
    m_run       = 0;
    m_busy      = 0;
    m_error     = 0;
    m_exp_valid = 0;
    last_l      = 0;
    last_r      = 0;
  endtask

  // Called right after the active edge with the inputs that edge sampled.
  task automatic model_edge(input bit v, input int d, input bit ld, input int idx);
    bit was_run;
    bit boundary;
    int dr;
    was_run     = m_run;
    boundary    = 0;
    m_exp_valid = 0;
    if (v) begin
      hist.push_back(d & 32'hFFFF);
      m_count++;
      if (m_count >= 2 * WS + 1) begin
        dr = 2 * WS - m_active;
        sb_l.push_back(hist[hist.size() - 1 - WS]);
        sb_r.push_back(hist[hist.size() - 1 - dr]);
        m_exp_valid = 1;
        boundary    = was_run && (m_pos == WS - 1);
        m_pos       = (m_pos == WS - 1) ? 0 : m_pos + 1;
        m_run       = 1;
      end
    end
    if (boundary && m_busy) begin
      m_active = m_pending;
      m_busy   = 0;
    end
    if (ld) begin
      if (idx <= MAXI) begin
        if (!was_run) m_active = idx;
        else begin
          m_pending = idx;
          m_busy    = 1;
        end
      end else begin
        m_error = 1;
      end
    end
  endtask

  task automatic check_outputs();
    int el, er;
    check_eq("out_valid", int'(out_valid), int'(m_exp_valid));
    if (out_valid) begin
      if (sb_l.size() == 0) begin
        check_eq("sb_underflow", sb_l.size(), 1);
      end else begin
        el = sb_l.pop_front();
        er = sb_r.pop_front();
        out_no++;
        $display("OUT %0d left=%0d right=%0d exp_left=%0d exp_right=%0d idx=%0d",
                 out_no, left_data_out, right_data_out, el, er, active_index);
        check_eq("left", int'(left_data_out), el);
        check_eq("right", int'(right_data_out), er);
        last_l = el;
        last_r = er;
      end
    end else begin
      check_eq("left_hold", int'(left_data_out), last_l);
      check_eq("right_hold", int'(right_data_out), last_r);
    end
    check_eq("active_index", int'(active_index), m_active);
    check_eq("steer_busy", int'(steer_busy), int'(m_busy));
    check_eq("steer_error", int'(steer_error), int'(m_error));
  endtask

  // One clock: drive at the falling edge, check at the next falling edge.
  task automatic step(input bit v, input int d, input bit ld, input int idx);
    sample_valid = v;
    sample_in    = DW'(d);
    steer_load   = ld;
    steer_index  = IW'(idx);
    @(posedge clk);
    model_edge(v, d, ld, idx);
    @(negedge clk);
    sample_valid = 1'b0;
    steer_load   = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    int acc;
    int cyc;
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    steer_index  = '0;
    steer_load   = 1'b0;
    out_no       = 0;
    model_reset();
    @(negedge clk);

    // 1: broadside, ramp; first output after sample 61 is 31/31
    do_reset();
    for (int k = 1; k <= 70; k++) step(1, k, 0, 0);

    // 2: index 60 loaded in FILL, right uses the bypass path
    do_reset();
    step(1, 1, 1, 60);
    for (int k = 2; k <= 100; k++) step(1, k, 0, 0);

    // 3: index 0, right lags left by WINDOW_SIZE
    do_reset();
    step(1, 1, 1, 0);
    for (int k = 2; k <= 100; k++) step(1, k, 0, 0);

    // 4: re-steer in RUN, last-wins, load on a boundary sample
    do_reset();
    for (int k = 1; k <= 185; k++) begin
      case (k)
        71:      step(1, k, 1, 45);  // frame position 10
        100:     step(1, k, 1, 20);
        101:     step(1, k, 1, 50);
        125:     step(1, k, 1, 10);
        150:     step(1, k, 1, 40);  // boundary sample
        default: step(1, k, 0, 0);
      endcase
    end

    // 5: out-of-range loads set the sticky error, nothing else changes
    step(1, 186, 1, 61);
    for (int k = 187; k <= 195; k++) step(1, k, 0, 0);
    step(0, 0, 1, 63);
    step(1, 196, 0, 0);
    do_reset();
    step(0, 0, 0, 0);

    // 6: gapped valid, asynchronous reset pulse right after sample 80
    do_reset();
    acc = 0;
    cyc = 0;
    while (acc < 80) begin
      cyc++;
      if (cyc % 3 == 0) begin
        acc++;
        step(1, int'($urandom_range(0, 65535)), (acc == 5) ? 1'b1 : 1'b0, 12);
      end else begin
        step(0, 0, 0, 0);
      end
    end
    #2 reset = 1'b1;
    #1;
    check_eq("async_out_valid", int'(out_valid), 0);
    check_eq("async_left", int'(left_data_out), 0);
    check_eq("async_right", int'(right_data_out), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
    acc = 0;
    cyc = 0;
    while (acc < 70) begin
      cyc++;
      if (cyc % 3 == 0) begin
        acc++;
        step(1, int'($urandom_range(0, 65535)), 0, 0);
      end else begin
        step(0, 0, 0, 0);
      end
    end
    check_eq("final_active_index", int'(active_index), WS);
    check_eq("sb_drain", sb_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
